// File: rtl/fp_addsub_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_arbiter_if
// Request and response channels of the shared FP add/sub arbiter.
//
//   req_valid  [NUM_REQ]    requester -> arbiter, per-requester request valid
//   req_ready  [NUM_REQ]    arbiter -> requester, one-hot accept (or zero)
//   req_a      [NUM_REQ*8]  operand A, requester i at [8i+7:8i]
//   req_b      [NUM_REQ*8]  operand B, same packing
//   req_op     [NUM_REQ]    0 = add, 1 = sub
//   rsp_valid               arbiter -> consumer, response valid
//   rsp_ready               consumer -> arbiter, response accepted
//   rsp_id     [ID_W]       requester that issued the response
//   rsp_result [8]          registered adder result
//   rsp_flags  [5]          registered adder flags {OF,UF,DZ,NV,NX}
//
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fp_addsub_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*8-1:0] req_a;
   logic [NUM_REQ*8-1:0] req_b;
   logic [NUM_REQ-1:0]   req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_result;
   logic [4:0]           rsp_flags;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
   );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// fp_addsub_arbiter
// Round-robin arbiter/sequencer sharing one combinational 8-bit FP
// adder/subtractor between NUM_REQ requesters. At most one operation is
// launched per cycle; its result and flags are captured into a single
// response register and returned with the requester ID.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   bus            fp_addsub_arbiter_if.slave (request + response channels)
//   fp_a_o/fp_b_o  operands to the shared adder
//   fp_op_o        operation to the shared adder (0 add, 1 sub)
//   fp_result_i    adder result (combinational from fp_a_o/fp_b_o/fp_op_o)
//   fp_flags_i     adder flags {OF,UF,DZ,NV,NX}
//   busy_o         high while a response is held
//
// Optional feature, macro FP_ARB_STICKY_FLAGS_EN:
//   sticky_flags_o [NUM_REQ*5]  per-requester accumulated flags
//   sticky_clr_i   [NUM_REQ]    per-requester synchronous clear (wins over OR)
// ---------------------------------------------------------------------------
module fp_addsub_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_addsub_arbiter_if.slave   bus,
   output logic [7:0]           fp_a_o,
   output logic [7:0]           fp_b_o,
   output logic                 fp_op_o,
   input  logic [7:0]           fp_result_i,
   input  logic [4:0]           fp_flags_i,
   output logic                 busy_o
`ifdef FP_ARB_STICKY_FLAGS_EN
   ,
   output logic [NUM_REQ*5-1:0] sticky_flags_o,
   input  logic [NUM_REQ-1:0]   sticky_clr_i
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [7:0]      rsp_result_q, rsp_result_d;
   logic [4:0]      rsp_flags_q, rsp_flags_d;

   logic               slot_free;
   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic               transfer;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [ID_W-1:0]    op_sel;

   logic [7:0] a_arr  [NUM_REQ];
   logic [7:0] b_arr  [NUM_REQ];
   logic       op_arr [NUM_REQ];

   // Unpack the flat operand buses into per-requester views.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = bus.req_a[8*gi +: 8];
      assign b_arr[gi]  = bus.req_b[8*gi +: 8];
      assign op_arr[gi] = bus.req_op[gi];
   end

   // Rotating priority search starting at rr_ptr_q; the sum is one bit wider
   // than the pointer so the wrap can be done with a single subtract.
   always_comb begin
      logic [ID_W:0] sum;
      grant_found = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && bus.req_valid[sum[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = sum[ID_W-1:0];
         end
      end
   end

   // The slot can take a new operation when nothing is held or the held
   // response is leaving this very cycle. Gating with rst_n keeps req_ready
   // low for the whole reset assertion, not only after the first edge.
   assign slot_free = (state_q == IDLE) | (rsp_valid_q & bus.rsp_ready);
   assign transfer  = rst_n & slot_free & grant_found;

   always_comb begin
      grant_onehot = '0;
      if (transfer) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

   assign bus.req_ready = grant_onehot;

   // Adder operands follow the grant; between grants they park on the last
   // requester that actually transferred.
   assign op_sel  = transfer ? grant_idx : last_grant_q;
   assign fp_a_o  = a_arr[op_sel];
   assign fp_b_o  = b_arr[op_sel];
   assign fp_op_o = op_arr[op_sel];

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;

      if (transfer) begin
         // A new result overwrites the draining one, so back-to-back
         // responses have no bubble.
         state_d      = RESP;
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_idx;
         rsp_result_d = fp_result_i;
         rsp_flags_d  = fp_flags_i;
         last_grant_d = grant_idx;
         if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + 1'b1;
         end
      end else if ((state_q == RESP) && bus.rsp_ready) begin
         // Drain only: payload fields keep their last values.
         state_d     = IDLE;
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign busy_o         = (state_q == RESP);

`ifdef FP_ARB_STICKY_FLAGS_EN
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sticky
      logic [4:0] sticky_q, sticky_d;

      // Clear wins over accumulation in the same cycle.
      always_comb begin
         sticky_d = sticky_q;
         if (sticky_clr_i[gi]) begin
            sticky_d = '0;
         end else if (transfer && (grant_idx == ID_W'(gi))) begin
            sticky_d = sticky_q | fp_flags_i;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sticky_q <= '0;
         end else begin
            sticky_q <= sticky_d;
         end
      end

      assign sticky_flags_o[5*gi +: 5] = sticky_q;
   end
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
module tb_fp_addsub_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_addsub_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

   logic [7:0] fp_a, fp_b, fp_result;
   logic       fp_op;
   logic [4:0] fp_flags;
   logic       busy;

   logic       flag_force_en  = 1'b0;
   logic [4:0] flag_force_val = 5'd0;

`ifdef FP_ARB_STICKY_FLAGS_EN
   logic [N*5-1:0] sticky_flags;
   logic [N-1:0]   sticky_clr = '0;
`endif

   fp_addsub_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .fp_a_o      (fp_a),
      .fp_b_o      (fp_b),
      .fp_op_o     (fp_op),
      .fp_result_i (fp_result),
      .fp_flags_i  (fp_flags),
      .busy_o      (busy)
`ifdef FP_ARB_STICKY_FLAGS_EN
      ,
      .sticky_flags_o (sticky_flags),
      .sticky_clr_i   (sticky_clr)
`endif
   );

   // Stand-in adder: any deterministic function works since the arbiter
   // only transports its outputs. Chosen so 0x38 + 0x38 gives 0x40.
   function automatic logic [7:0] add_res(logic [7:0] a, logic [7:0] b, logic op);
      return op ? (a - b) : (a + b - 8'h30);
   endfunction

   function automatic logic [4:0] add_flg(logic [7:0] a, logic [7:0] b, logic op);
      logic [7:0] x;
      x = a ^ b;
      return flag_force_en ? flag_force_val : (x[4:0] ^ {4'b0, op});
   endfunction

   assign fp_result = add_res(fp_a, fp_b, fp_op);
   assign fp_flags  = add_flg(fp_a, fp_b, fp_op);

   int checks   = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: one held response slot plus a rotating pointer.
   bit         m_valid = 0;
   int         m_id    = 0;
   int         m_ptr   = 0;
   logic [7:0] m_res   = '0;
   logic [4:0] m_flg   = '0;
   logic [4:0] m_sticky [N];

   always @(negedge clk) begin : compare
      int g;
      int idx;
      bit sf;
      logic [7:0] ea, eb;
      logic       eo;
      if (!rst_n) begin
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rsp_id", bus.rsp_id, 0);
         chk("rst_rsp_result", bus.rsp_result, 0);
         chk("rst_rsp_flags", bus.rsp_flags, 0);
         m_valid = 0; m_id = 0; m_ptr = 0; m_res = '0; m_flg = '0;
         for (int i = 0; i < N; i++) m_sticky[i] = '0;
      end else begin
         g  = -1;
         sf = !m_valid || bus.rsp_ready;
         if (sf) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (g < 0 && bus.req_valid[idx]) g = idx;
            end
         end
         chk("req_ready", bus.req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
         chk("rsp_valid", bus.rsp_valid, m_valid);
         chk("busy", busy, m_valid);
         chk("rsp_id", bus.rsp_id, m_id);
         chk("rsp_result", bus.rsp_result, m_res);
         chk("rsp_flags", bus.rsp_flags, m_flg);
`ifdef FP_ARB_STICKY_FLAGS_EN
         for (int i = 0; i < N; i++) chk("sticky", sticky_flags[i*5 +: 5], m_sticky[i]);
`endif
         if (g >= 0) begin
            ea = bus.req_a[g*8 +: 8];
            eb = bus.req_b[g*8 +: 8];
            eo = bus.req_op[g];
            chk("fp_a", fp_a, ea);
            chk("fp_b", fp_b, eb);
            chk("fp_op", fp_op, eo);
            $display("txn: grant=%0d a=%02h b=%02h op=%0d", g, ea, eb, eo);
            m_valid = 1;
            m_id    = g;
            m_res   = add_res(ea, eb, eo);
            m_flg   = add_flg(ea, eb, eo);
            m_ptr   = (g + 1) % N;
         end else if (m_valid && bus.rsp_ready) begin
            m_valid = 0;
         end
`ifdef FP_ARB_STICKY_FLAGS_EN
         for (int i = 0; i < N; i++) begin
            if (sticky_clr[i]) m_sticky[i] = '0;
            else if (g == i) m_sticky[i] = m_sticky[i] | add_flg(ea, eb, eo);
         end
`endif
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_edge();
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      sample();
      rst_n = 1'b1;
   endtask

   int seq [6] = '{0, 1, 2, 3, 0, 1};
   logic [7:0] snap_res;
   logic [4:0] snap_flg;
   int         snap_id;

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) m_sticky[i] = '0;

      // Reset state.
      sample();
      chk("lit_rst_valid", bus.rsp_valid, 0);
      chk("lit_rst_ready", bus.req_ready, 0);
      rst_n = 1'b1;

      // Single request from requester 0.
      drive_edge();
      bus.req_valid = 4'b0001;
      bus.req_a     = 32'h0000_0038;
      bus.req_b     = 32'h0000_0038;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b1;
      sample();
      chk("lit_single_ready", bus.req_ready, 4'b0001);
      chk("lit_single_fp_a", fp_a, 8'h38);
      drive_edge();
      bus.req_valid = '0;
      sample();
      chk("lit_single_valid", bus.rsp_valid, 1);
      chk("lit_single_id", bus.rsp_id, 0);
      chk("lit_single_result", bus.rsp_result, 8'h40);
      chk("lit_single_flags", bus.rsp_flags, 5'h00);
      chk("lit_single_ptr", m_ptr, 1);

      // Fairness: everyone valid, consumer always ready.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive_edge();
         bus.req_valid = 4'hF;
         bus.rsp_ready = 1'b1;
         bus.req_a     = $urandom;
         bus.req_b     = $urandom;
         bus.req_op    = 4'($urandom);
         sample();
         chk("lit_fair_grant", bus.req_ready, 32'd1 << seq[k]);
         if (k > 0) begin
            chk("lit_fair_rsp_id", bus.rsp_id, seq[k-1]);
            chk("lit_fair_rsp_valid", bus.rsp_valid, 1);
         end
      end

      // Backpressure for five cycles with requests pending.
      drive_edge();
      bus.rsp_ready = 1'b0;
      sample();
      snap_res = bus.rsp_result;
      snap_flg = bus.rsp_flags;
      snap_id  = bus.rsp_id;
      chk("lit_bp_id", snap_id, 1);
      for (int i = 0; i < 5; i++) begin
         chk("lit_bp_ready", bus.req_ready, 0);
         chk("lit_bp_valid", bus.rsp_valid, 1);
         chk("lit_bp_result", bus.rsp_result, snap_res);
         chk("lit_bp_flags", bus.rsp_flags, snap_flg);
         chk("lit_bp_hold_id", bus.rsp_id, snap_id);
         if (i < 4) sample();
      end
      drive_edge();
      bus.rsp_ready = 1'b1;
      sample();
      chk("lit_bp_release_grant", bus.req_ready, 4'b0100);

      // Wrap/skip: pointer now 3, only requester 1 valid.
      drive_edge();
      bus.req_valid = 4'b0010;
      sample();
      chk("lit_bp_next_id", bus.rsp_id, 2);
      chk("lit_wrap_grant", bus.req_ready, 4'b0010);
      drive_edge();
      bus.req_valid = '0;
      sample();
      chk("lit_wrap_id", bus.rsp_id, 1);
      chk("lit_wrap_ptr", m_ptr, 2);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         drive_edge();
         bus.req_valid = 4'($urandom);
         bus.req_a     = $urandom;
         bus.req_b     = $urandom;
         bus.req_op    = 4'($urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end

      // Reset while a response is held under backpressure.
      drive_edge();
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b0;
      drive_edge();
      sample();
      chk("lit_mid_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("lit_mid_rst_valid", bus.rsp_valid, 0);
      chk("lit_mid_rst_ready", bus.req_ready, 0);
      chk("lit_mid_rst_busy", busy, 0);
      sample();
      rst_n = 1'b1;
      #1;
      chk("lit_mid_first_grant", bus.req_ready, 4'b0001);

`ifdef FP_ARB_STICKY_FLAGS_EN
      do_reset();
      drive_edge();
      bus.rsp_ready  = 1'b1;
      flag_force_en  = 1'b1;
      flag_force_val = 5'b10000;
      bus.req_valid  = 4'b0100;
      drive_edge();
      flag_force_val = 5'b00001;
      drive_edge();
      bus.req_valid = '0;
      sample();
      chk("lit_sticky_or", sticky_flags[14:10], 5'b10001);
      drive_edge();
      bus.req_valid  = 4'b0100;
      sticky_clr     = 4'b0100;
      flag_force_val = 5'b00001;
      drive_edge();
      bus.req_valid = '0;
      sticky_clr    = '0;
      sample();
      chk("lit_sticky_clr", sticky_flags[14:10], 5'b00000);
      flag_force_en = 1'b0;
`endif

      drive_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
